// File: rtl/color_lut_loader.sv
// Sequences a full 3D-LUT table from a host stream into the colour-mapping config port, starting only at vsync.
// Latency: one cycle from an accepted entry to o_cfg_valid/o_cfg_data; status pulses align with that cfg beat.
// Backpressure: s_ready is high only in LOAD/FLUSH; the loader never stalls an accepted stream (one entry per cycle).
module color_lut_loader #(
  parameter int GS     = 33,
  parameter int LUT_CD = 8,
  parameter bit VS_POL = 1'b1,
  localparam int N     = GS * GS * GS,
  localparam int CW    = $clog2(N + 1)
) (
  input  logic                  p_clk,
  input  logic                  p_rst,
  input  logic                  i_vs,
  input  logic                  i_load_req,
  input  logic [LUT_CD*3-1:0]   s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [LUT_CD*3-1:0]   o_cfg_data,
  output logic                  o_cfg_valid,
  output logic                  o_cfg_last,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [1:0]            o_err_code,
  output logic [CW-1:0]         o_entry_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_LOAD    = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [1:0]    ERR_NONE  = 2'd0;
  localparam logic [1:0]    ERR_SHORT = 2'd1;
  localparam logic [1:0]    ERR_LONG  = 2'd2;

  state_t state;
  logic   vs_q;
  logic   vs_start;
  logic   xfer;

  // Only the entry of vsync into its active level opens a load window.
  assign vs_start = (i_vs == VS_POL) && (vs_q != VS_POL);

  // Entries are accepted while loading, and swallowed while flushing an over-long stream.
  assign s_ready  = (state == ST_LOAD) || (state == ST_FLUSH);
  assign o_busy   = (state != ST_IDLE);
  assign xfer     = s_valid && s_ready;

  // Loader FSM with registered cfg beat, status pulses, error code and entry count.
  always_ff @(posedge p_clk) begin
    if (p_rst) begin
      state       <= ST_IDLE;
      vs_q        <= ~VS_POL;
      o_cfg_data  <= '0;
      o_cfg_valid <= 1'b0;
      o_cfg_last  <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_err_code  <= ERR_NONE;
      o_entry_cnt <= '0;
    end else begin
      vs_q        <= i_vs;
      o_cfg_valid <= 1'b0;
      o_cfg_last  <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_load_req) begin
            state       <= ST_WAIT_VS;
            o_entry_cnt <= '0;
            o_err_code  <= ERR_NONE;
          end
        end
        ST_WAIT_VS: begin
          // vs_start cannot be seen in the request cycle, since we were still IDLE then.
          if (vs_start) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            o_cfg_data  <= s_data;
            o_cfg_valid <= 1'b1;
            o_entry_cnt <= o_entry_cnt + CW'(1);
            if (o_entry_cnt == LAST_IDX) begin
              // Table is complete either way; a missing s_last means the host keeps sending.
              o_cfg_last <= 1'b1;
              if (s_last) begin
                o_done <= 1'b1;
                state  <= ST_IDLE;
              end else begin
                o_err      <= 1'b1;
                o_err_code <= ERR_LONG;
                state      <= ST_FLUSH;
              end
            end else if (s_last) begin
              // Stream ended early: RAM keeps a partial table without a last marker.
              o_err      <= 1'b1;
              o_err_code <= ERR_SHORT;
              state      <= ST_IDLE;
            end
          end
        end
        ST_FLUSH: begin
          if (xfer && s_last) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_color_lut_loader.sv
// Bench for color_lut_loader with GS=2 (N=8): scenario tasks plus a cfg-beat scoreboard.
// Expected cfg beats are queued when an entry is driven and checked one cycle later.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_color_lut_loader;

  localparam int GS = 2;
  localparam int CD = 8;
  localparam int W  = CD * 3;
  localparam int CW = $clog2(GS*GS*GS + 1);

  logic          p_clk;
  logic          p_rst;
  logic          i_vs;
  logic          i_load_req;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [W-1:0]  o_cfg_data;
  logic          o_cfg_valid;
  logic          o_cfg_last;
  logic          o_busy;
  logic          o_done;
  logic          o_err;
  logic [1:0]    o_err_code;
  logic [CW-1:0] o_entry_cnt;

  // bench-side expectation controls, set together with the stimulus
  logic exp_ready;
  logic fwd;
  logic fwd_last;

  logic [W:0] exp_q[$];

  int checks = 0;
  int failures = 0;
  int cfg_seen = 0;
  int last_seen = 0;
  int done_seen = 0;
  int err_seen = 0;
  logic [1:0]    err_code_seen = 2'd0;
  logic [CW-1:0] err_cnt_seen = '0;

  color_lut_loader #(
    .GS(GS),
    .LUT_CD(CD),
    .VS_POL(1'b1)
  ) dut (
    .p_clk(p_clk),
    .p_rst(p_rst),
    .i_vs(i_vs),
    .i_load_req(i_load_req),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_last(s_last),
    .s_ready(s_ready),
    .o_cfg_data(o_cfg_data),
    .o_cfg_valid(o_cfg_valid),
    .o_cfg_last(o_cfg_last),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_err(o_err),
    .o_err_code(o_err_code),
    .o_entry_cnt(o_entry_cnt)
  );

  initial begin
    p_clk = 1'b0;
    forever #5 p_clk = ~p_clk;
  end

  // scoreboard / protocol monitor
  always @(negedge p_clk) begin
    logic [W:0] e;
    checks++;
    if (s_ready !== exp_ready) begin
      failures++;
      $display("FAIL s_ready t=%0t: got %b expected %b", $time, s_ready, exp_ready);
    end
    checks++;
    if (o_cfg_valid !== (exp_q.size() != 0)) begin
      failures++;
      $display("FAIL cfg_valid t=%0t: got %b expected %b", $time, o_cfg_valid, exp_q.size() != 0);
    end
    if (o_cfg_valid === 1'b1) begin
      cfg_seen++;
      if (o_cfg_last === 1'b1) last_seen++;
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (o_cfg_valid === 1'b1) begin
        checks++;
        if ({o_cfg_last, o_cfg_data} !== e) begin
          failures++;
          $display("FAIL cfg_beat t=%0t: got last=%b data=%06h expected last=%b data=%06h",
                   $time, o_cfg_last, o_cfg_data, e[W], e[W-1:0]);
        end
      end
    end
    checks++;
    if (o_cfg_last === 1'b1 && o_cfg_valid !== 1'b1) begin
      failures++;
      $display("FAIL cfg_last_alone t=%0t: got last=1 valid=%b expected valid=1", $time, o_cfg_valid);
    end
    if (o_done === 1'b1) begin
      done_seen++;
      checks++;
      if (o_cfg_last !== 1'b1) begin
        failures++;
        $display("FAIL done_align t=%0t: got cfg_last=%b expected 1", $time, o_cfg_last);
      end
    end
    if (o_err === 1'b1) begin
      err_seen++;
      err_code_seen = o_err_code;
      err_cnt_seen  = o_entry_cnt;
      checks++;
      if (o_cfg_valid !== 1'b1) begin
        failures++;
        $display("FAIL err_align t=%0t: got cfg_valid=%b expected 1", $time, o_cfg_valid);
      end
    end
    if (s_valid === 1'b1 && exp_ready === 1'b1 && fwd === 1'b1)
      exp_q.push_back({fwd_last, s_data});
  end

  task automatic cyc();
    @(posedge p_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge p_clk);
    #1;
  endtask

  // Request a load, hold off for wait_cyc cycles, then produce a vsync rising edge.
  task automatic start_load(input int wait_cyc, input bit hold, input bit vs_pre);
    i_vs      = vs_pre;
    s_valid   = hold;
    s_data    = 24'h000001;
    s_last    = 1'b0;
    fwd       = 1'b1;
    fwd_last  = 1'b0;
    exp_ready = 1'b0;
    cyc();
    cyc();
    i_load_req = 1'b1;
    cyc();
    i_load_req = 1'b0;
    repeat (wait_cyc) cyc();
    if (vs_pre) begin
      i_vs = 1'b0;
      cyc();
    end
    i_vs = 1'b1;
    cyc();
    i_vs      = 1'b0;
    exp_ready = 1'b1;
  endtask

  // Stream n entries 1..n; first 8 are forwarded, the 8th marked last.
  task automatic stream(input int n, input bit gap, input int req_at, input bit with_last);
    for (int i = 0; i < n; i++) begin
      s_valid    = 1'b1;
      s_data     = 24'(i + 1);
      s_last     = with_last && (i == n - 1);
      fwd        = (i < 8);
      fwd_last   = (i == 7);
      exp_ready  = 1'b1;
      i_load_req = (i == req_at);
      cyc();
      i_load_req = 1'b0;
      if (gap && i < n - 1) begin
        s_valid = 1'b0;
        cyc();
      end
    end
    s_valid   = 1'b0;
    s_last    = 1'b0;
    fwd       = 1'b0;
    exp_ready = !with_last;
  endtask

  task automatic check_end(input string nm, input int c0, input int l0, input int d0, input int e0,
                           input int exp_cfg, input int exp_last, input int exp_done, input int exp_err,
                           input logic [1:0] exp_code, input logic [CW-1:0] exp_cnt);
    sample();
    checks++;
    if (cfg_seen - c0 != exp_cfg) begin
      failures++;
      $display("FAIL %s_cfg_count: got %0d expected %0d", nm, cfg_seen - c0, exp_cfg);
    end
    checks++;
    if (last_seen - l0 != exp_last) begin
      failures++;
      $display("FAIL %s_last_count: got %0d expected %0d", nm, last_seen - l0, exp_last);
    end
    checks++;
    if (done_seen - d0 != exp_done) begin
      failures++;
      $display("FAIL %s_done_count: got %0d expected %0d", nm, done_seen - d0, exp_done);
    end
    checks++;
    if (err_seen - e0 != exp_err) begin
      failures++;
      $display("FAIL %s_err_count: got %0d expected %0d", nm, err_seen - e0, exp_err);
    end
    checks++;
    if (o_err_code !== exp_code) begin
      failures++;
      $display("FAIL %s_err_code: got %0d expected %0d", nm, o_err_code, exp_code);
    end
    checks++;
    if (o_entry_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL %s_entry_cnt: got %0d expected %0d", nm, o_entry_cnt, exp_cnt);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy: got %b expected 0", nm, o_busy);
    end
  endtask

  task automatic test_reset();
    sample();
    checks++;
    if (o_cfg_valid !== 1'b0 || o_cfg_last !== 1'b0 || o_done !== 1'b0 || o_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: got v=%b l=%b d=%b e=%b expected 0", o_cfg_valid, o_cfg_last, o_done, o_err);
    end
    checks++;
    if (o_err_code !== 2'd0 || o_entry_cnt !== '0 || o_cfg_data !== '0) begin
      failures++;
      $display("FAIL reset_values: got code=%0d cnt=%0d data=%06h expected 0", o_err_code, o_entry_cnt, o_cfg_data);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b expected 0", o_busy);
    end
  endtask

  task automatic test_nominal();
    int c0 = cfg_seen, l0 = last_seen, d0 = done_seen, e0 = err_seen;
    start_load(2, 1'b0, 1'b0);
    checks++;
    if (o_busy !== 1'b1) begin
      failures++;
      $display("FAIL nominal_busy_loading: got %b expected 1", o_busy);
    end
    stream(8, 1'b0, -1, 1'b1);
    check_end("nominal", c0, l0, d0, e0, 8, 1, 1, 0, 2'd0, 4'd8);
  endtask

  task automatic test_vsync_gating();
    int c0 = cfg_seen, l0 = last_seen, d0 = done_seen, e0 = err_seen;
    start_load(20, 1'b1, 1'b0);
    stream(8, 1'b0, -1, 1'b1);
    check_end("vs_low", c0, l0, d0, e0, 8, 1, 1, 0, 2'd0, 4'd8);
    c0 = cfg_seen; l0 = last_seen; d0 = done_seen; e0 = err_seen;
    start_load(5, 1'b1, 1'b1);
    stream(8, 1'b0, -1, 1'b1);
    check_end("vs_high", c0, l0, d0, e0, 8, 1, 1, 0, 2'd0, 4'd8);
  endtask

  task automatic test_short();
    int c0 = cfg_seen, l0 = last_seen, d0 = done_seen, e0 = err_seen;
    start_load(2, 1'b0, 1'b0);
    stream(5, 1'b0, -1, 1'b1);
    check_end("short", c0, l0, d0, e0, 5, 0, 0, 1, 2'd1, 4'd5);
    checks++;
    if (err_code_seen !== 2'd1 || err_cnt_seen !== 4'd5) begin
      failures++;
      $display("FAIL short_err_pulse: got code=%0d cnt=%0d expected code=1 cnt=5", err_code_seen, err_cnt_seen);
    end
  endtask

  task automatic test_long();
    int c0 = cfg_seen, l0 = last_seen, d0 = done_seen, e0 = err_seen;
    start_load(2, 1'b0, 1'b0);
    stream(11, 1'b0, -1, 1'b1);
    check_end("long", c0, l0, d0, e0, 8, 1, 0, 1, 2'd2, 4'd8);
    checks++;
    if (err_code_seen !== 2'd2 || err_cnt_seen !== 4'd8) begin
      failures++;
      $display("FAIL long_err_pulse: got code=%0d cnt=%0d expected code=2 cnt=8", err_code_seen, err_cnt_seen);
    end
  endtask

  task automatic test_gaps_ignored_req();
    int c0 = cfg_seen, l0 = last_seen, d0 = done_seen, e0 = err_seen;
    start_load(2, 1'b0, 1'b0);
    stream(8, 1'b1, 3, 1'b1);
    check_end("gaps", c0, l0, d0, e0, 8, 1, 1, 0, 2'd0, 4'd8);
    repeat (3) cyc();
    sample();
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL gaps_req_queued: got busy=%b expected 0", o_busy);
    end
  endtask

  task automatic test_reset_midload();
    int c0, l0, d0, e0;
    start_load(2, 1'b0, 1'b0);
    d0 = done_seen; e0 = err_seen;
    stream(4, 1'b0, -1, 1'b0);
    p_rst = 1'b1;
    cyc();
    p_rst     = 1'b0;
    exp_ready = 1'b0;
    sample();
    checks++;
    if (o_busy !== 1'b0 || o_cfg_valid !== 1'b0 || o_entry_cnt !== '0 || o_err_code !== 2'd0) begin
      failures++;
      $display("FAIL midreset_outputs: got busy=%b v=%b cnt=%0d code=%0d expected 0",
               o_busy, o_cfg_valid, o_entry_cnt, o_err_code);
    end
    checks++;
    if (done_seen != d0 || err_seen != e0) begin
      failures++;
      $display("FAIL midreset_pulses: got done=%0d err=%0d expected 0 0", done_seen - d0, err_seen - e0);
    end
    c0 = cfg_seen; l0 = last_seen; d0 = done_seen; e0 = err_seen;
    start_load(2, 1'b0, 1'b0);
    stream(8, 1'b0, -1, 1'b1);
    check_end("after_reset", c0, l0, d0, e0, 8, 1, 1, 0, 2'd0, 4'd8);
  endtask

  initial begin
    p_rst      = 1'b1;
    i_vs       = 1'b0;
    i_load_req = 1'b0;
    s_data     = '0;
    s_valid    = 1'b0;
    s_last     = 1'b0;
    exp_ready  = 1'b0;
    fwd        = 1'b0;
    fwd_last   = 1'b0;
    repeat (3) cyc();
    test_reset();
    cyc();
    p_rst = 1'b0;
    cyc();
    test_nominal();
    test_vsync_gating();
    test_short();
    test_long();
    test_gaps_ignored_req();
    test_reset_midload();
    repeat (2) cyc();
    sample();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
